rx_fifo: RTL and testbench
==========================

RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter NBIT_DATA, default 8, byte width; equals the upstream receiver's data width.
REQ-002 Parameter DEPTH_LOG2, default 3, log2 of FIFO depth; DEPTH = 2^DEPTH_LOG2 = 8 entries.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx_done_tick  input  1  receiver completion flag; may stay high for many clk cycles (one baud-tick period).
REQ-006 data_in  input  NBIT_DATA  received byte; valid while rx_done_tick is high.
REQ-007 rd_en  input  1  consumer pop request, one pop per high cycle.
REQ-008 data_out  output  NBIT_DATA  head-of-FIFO byte (show-ahead).
REQ-009 empty  output  1  high when count == 0.
REQ-010 full  output  1  high when count == DEPTH.
REQ-011 count  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
REQ-012 ovf  output  1  sticky overrun flag.
REQ-013 ovf_clr  input  1  single-cycle clear of ovf.

Function
REQ-014 A write event SHALL be the cycle where rx_done_tick is 1 and its registered previous value is 0; exactly one write per high level regardless of duration.
REQ-015 On a write event with full == 0, data_in SHALL be stored at wr_ptr, wr_ptr incremented modulo DEPTH, count incremented; visible the next cycle.
REQ-016 On a write event with full == 1 and no accepted pop that cycle, the byte SHALL be dropped; memory, pointers and count unchanged.
REQ-017 A pop SHALL occur when rd_en == 1 and empty == 0: rd_ptr incremented modulo DEPTH, count decremented next cycle.
REQ-018 rd_en with empty == 1 SHALL be ignored; no pointer or count change.
REQ-019 data_out SHALL equal mem[rd_ptr] combinationally when empty == 0, and all zeros when empty == 1.
REQ-020 Simultaneous write event and pop while full SHALL accept both; count stays DEPTH.
REQ-021 Simultaneous write event and rd_en while empty SHALL accept the write only (no bypass); count becomes 1.
REQ-022 Simultaneous write and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-023 Pointers SHALL be DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0.
REQ-024 empty, full SHALL be decoded from registered count; no extra latency beyond count.

Reset
REQ-025 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, count, the rx_done_tick history register and ovf; empty = 1, full = 0, data_out = 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 If rst_n deasserts while rx_done_tick is already high, no write SHALL occur until rx_done_tick falls and rises again.
REQ-028 Reset asserted mid-operation SHALL discard all stored bytes immediately.

Configuration
REQ-029 Macro RX_FIFO_OVF_EN: when defined, ovf SHALL set the cycle after a dropped write (REQ-016) and stay set until a cycle with ovf_clr == 1; set wins over simultaneous clear.
REQ-030 Without RX_FIFO_OVF_EN, ovf SHALL be constant 0, ovf_clr ignored, no overrun register synthesized; port list unchanged.

Verification
REQ-031 Reset, then rx_done_tick high 16 cycles with data_in = 8'hA5 -> count = 1 (not 16), data_out = 8'hA5, empty = 0.
REQ-032 Write 8'h01..8'h08 as eight pulses, then 8'h09 -> full = 1, count = 8, 8'h09 dropped; pops return 8'h01..8'h08 in order; ovf = 1 only with RX_FIFO_OVF_EN.
REQ-033 FIFO full, write event 8'h55 coincident with rd_en -> 8'h01 popped, 8'h55 stored at tail, count stays 8, ovf unchanged.
REQ-034 Empty FIFO, rd_en high with write event 8'h3C -> count = 1, data_out = 8'h3C; then rd_en alone with empty -> no change.
REQ-035 Write 6, pop 6, write 5 bytes 8'hE0..8'hE4 -> pointers wrap past 7, pops return 8'hE0..8'hE4 in order.
REQ-036 count = 4, assert rst_n low mid-cycle -> empty = 1, count = 0, data_out = 0 immediately without waiting for clk.

Source files
------------

// File: rtl/rx_fifo.sv
// Receive byte FIFO with rising-edge capture of rx_done_tick and show-ahead read port.
// Optional sticky overrun flag enabled by defining RX_FIFO_OVF_EN.
module rx_fifo #(
    parameter int NBIT_DATA  = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_done_tick,
    input  logic [NBIT_DATA-1:0]  data_in,
    input  logic                  rd_en,
    output logic [NBIT_DATA-1:0]  data_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int                     DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    CNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]    CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [NBIT_DATA-1:0]  r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_tick_q;
    logic                  r_armed;

    logic w_wev;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    // r_armed blocks a capture when the tick is already high as reset releases
    assign w_wev  = rx_done_tick & ~r_tick_q & r_armed;
    assign w_pop  = rd_en & ~empty;
    assign w_wr   = w_wev & (~full | w_pop);
    assign w_drop = w_wev & full & ~w_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_MAX);
    assign count    = r_count;
    assign data_out = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_tick_q <= rx_done_tick;
            if (!rx_done_tick)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RX_FIFO_OVF_EN
    logic r_ovf;

    // a drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    assign ovf = r_ovf;
`else
    logic w_unused;

    assign w_unused = ovf_clr ^ w_drop;
    assign ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Scoreboard bench for rx_fifo: accepted bytes queued at issue, checked on each pop.
// Directed scenarios cover edge capture, overrun, concurrent access, wrap and reset.
module tb_rx_fifo;

`ifdef RX_FIFO_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_done_tick;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;
    logic       ovf_clr;

    logic [7:0] sb [$];
    int         total = 0;
    int         bad   = 0;

    rx_fifo #(.NBIT_DATA(8), .DEPTH_LOG2(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_done_tick (rx_done_tick),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic [7:0] m_exp;
    always @(negedge clk) begin
        if (rst_n && rd_en && !empty) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_extra: got %0h want none", data_out);
            end else begin
                m_exp = sb.pop_front();
                chk("pop_data", {24'h0, data_out}, {24'h0, m_exp});
            end
        end
    end

    task automatic wr(input logic [7:0] d, input int hold, input bit acc);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        data_in      = d;
        if (acc) sb.push_back(d);
        repeat (hold) @(posedge clk);
        #1 rx_done_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr_pop(input logic [7:0] d, input bit acc);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        data_in      = d;
        rd_en        = 1'b1;
        if (acc) sb.push_back(d);
        @(posedge clk); #1;
        rd_en        = 1'b0;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pop();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        rx_done_tick = 1'b0;
        data_in      = 8'h00;
        rd_en        = 1'b0;
        ovf_clr      = 1'b0;
        #12;
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_dout", {24'h0, data_out}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        wr(8'hA5, 16, 1'b1);
        chk("long_tick_count", {28'h0, count}, 32'h1);
        chk("long_tick_dout", {24'h0, data_out}, 32'hA5);
        chk("long_tick_empty", {31'h0, empty}, 32'h0);
        pop();

        for (int i = 1; i <= 8; i++) wr(i[7:0], 1, 1'b1);
        wr(8'h09, 1, 1'b0);
        chk("ovr_full", {31'h0, full}, 32'h1);
        chk("ovr_count", {28'h0, count}, 32'h8);
        chk("ovr_flag", {31'h0, ovf}, {31'h0, OVF_ON});
        chk("ovr_head", {24'h0, data_out}, 32'h01);

        wr_pop(8'h55, 1'b1);
        chk("fullrw_count", {28'h0, count}, 32'h8);
        chk("fullrw_full", {31'h0, full}, 32'h1);
        chk("fullrw_ovf", {31'h0, ovf}, {31'h0, OVF_ON});
        chk("fullrw_head", {24'h0, data_out}, 32'h02);

        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("ovf_clr", {31'h0, ovf}, 32'h0);

        repeat (8) pop();
        chk("drain_empty", {31'h0, empty}, 32'h1);
        chk("drain_dout", {24'h0, data_out}, 32'h0);

        wr_pop(8'h3C, 1'b1);
        chk("emptyrw_count", {28'h0, count}, 32'h1);
        chk("emptyrw_dout", {24'h0, data_out}, 32'h3C);
        pop();
        pop();
        chk("rd_empty_count", {28'h0, count}, 32'h0);
        chk("rd_empty_flag", {31'h0, empty}, 32'h1);

        @(posedge clk); #1;
        rst_n        = 1'b0;
        rx_done_tick = 1'b1;
        data_in      = 8'h77;
        #10 rst_n = 1'b1;
        sb.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("tick_at_rst_count", {28'h0, count}, 32'h0);
        rx_done_tick = 1'b0;
        wr(8'h78, 1, 1'b1);
        chk("rearm_count", {28'h0, count}, 32'h1);
        chk("rearm_dout", {24'h0, data_out}, 32'h78);
        pop();

        do_reset();
        for (int i = 0; i < 6; i++) wr(8'h10 + i[7:0], 1, 1'b1);
        repeat (6) pop();
        for (int i = 0; i < 5; i++) wr(8'hE0 + i[7:0], 1, 1'b1);
        chk("wrap_count", {28'h0, count}, 32'h5);
        chk("wrap_head", {24'h0, data_out}, 32'hE0);
        repeat (5) pop();
        chk("wrap_empty", {31'h0, empty}, 32'h1);

        for (int i = 0; i < 4; i++) wr(8'hC0 + i[7:0], 1, 1'b0);
        chk("mid_count", {28'h0, count}, 32'h4);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_empty", {31'h0, empty}, 32'h1);
        chk("async_count", {28'h0, count}, 32'h0);
        chk("async_dout", {24'h0, data_out}, 32'h0);
        #10 rst_n = 1'b1;

        chk("sb_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
